best_arr_sender: RTL

//  Transmit side of the result stream. After the search FSM finishes, this block reads the

---
 rtl/best_arr_sender.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/best_arr_sender.sv
// Streams the best-match index memory to the output FIFO in blocked order (px > x > y > xi).
// Optional header word (NUM_QUERYS) ahead of the data when BEST_SEND_HEADER_EN is defined.
module best_arr_sender #(
  parameter int DATA_WIDTH = 11,
  parameter int IDX_WIDTH  = 9,
  parameter int ROW_SIZE   = 26,
  parameter int COL_SIZE   = 19,
  parameter int BLOCKING   = 4,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int ADDRW      = $clog2(NUM_QUERYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ren,
  output logic [ADDRW-1:0]      mem_addr,
  input  logic [IDX_WIDTH-1:0]  mem_rdata,
  output logic                  fifo_wenq,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_wfull_n
);

  localparam int HALF    = ROW_SIZE / 2;
  localparam int NXB     = (HALF + BLOCKING - 1) / BLOCKING;
  localparam int XW      = (NXB > 1) ? $clog2(NXB) : 1;
  localparam int YW      = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int LW      = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;
  localparam int LAST_XI = HALF - 1 - (NXB - 1) * BLOCKING;
`ifdef BEST_SEND_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                px_q, px_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [LW-1:0]       xi_q, xi_d;
  logic                rvld_q;
  logic [IDX_WIDTH-1:0] buf_q [2];
  logic                wr_q, rd_q;
  logic [1:0]          cnt_q;

  logic                avail, data_wen, hdr_wen, can_issue, last_pos, push_buf, pop_buf;
  logic [2:0]          occ_nxt;
  logic [IDX_WIDTH-1:0] head;
  logic [31:0]         addr_full;
  int                  lane_nxt;

  // Words owned by this block: buffered entries plus the read returning this cycle.
  assign avail     = (cnt_q != 2'd0) || rvld_q;
  assign data_wen  = avail && fifo_wfull_n;
  // Credit counts this cycle's pop so a steady stream sustains one word per cycle.
  assign occ_nxt   = {1'b0, cnt_q} + {2'b00, rvld_q} - {2'b00, data_wen};
  assign can_issue = occ_nxt < 3'd2;
  assign last_pos  = px_q && (x_q == XW'(NXB - 1)) && (y_q == YW'(COL_SIZE - 1)) &&
                     (xi_q == LW'(LAST_XI));
  assign lane_nxt  = int'(x_q) * BLOCKING + int'(xi_q) + 1;
  assign addr_full = 32'(px_q) * HALF + 32'(y_q) * ROW_SIZE + 32'(x_q) * BLOCKING + 32'(xi_q);
  assign mem_addr  = addr_full[ADDRW-1:0];

  // An empty buffer lets the returning read bypass straight to the FIFO.
  assign head       = (cnt_q != 2'd0) ? buf_q[rd_q] : mem_rdata;
  assign fifo_wenq  = hdr_wen || data_wen;
  assign fifo_wdata = hdr_wen  ? DATA_WIDTH'(NUM_QUERYS) :
                      data_wen ? DATA_WIDTH'(head) : '0;
  assign push_buf   = rvld_q && !((cnt_q == 2'd0) && data_wen);
  assign pop_buf    = data_wen && (cnt_q != 2'd0);

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    x_d     = x_q;
    y_d     = y_q;
    xi_d    = xi_q;
    busy    = 1'b0;
    done    = 1'b0;
    mem_ren = 1'b0;
    hdr_wen = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = HDR_EN ? S_HDR : S_RUN;
        px_d = 1'b0; x_d = '0; y_d = '0; xi_d = '0;
      end
      S_HDR: begin
        busy    = 1'b1;
        hdr_wen = fifo_wfull_n;
        if (fifo_wfull_n) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (can_issue) begin
          mem_ren = 1'b1;
          if (last_pos) state_d = S_DRAIN;
          // Lanes past the half-row edge are skipped without spending a cycle.
          if ((xi_q != LW'(BLOCKING - 1)) && (lane_nxt < HALF)) begin
            xi_d = xi_q + 1'b1;
          end else begin
            xi_d = '0;
            if (y_q != YW'(COL_SIZE - 1)) y_d = y_q + 1'b1;
            else begin
              y_d = '0;
              if (x_q != XW'(NXB - 1)) x_d = x_q + 1'b1;
              else begin
                x_d  = '0;
                px_d = ~px_q;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!avail) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      px_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      xi_q     <= '0;
      rvld_q   <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xi_q    <= xi_d;
      rvld_q  <= mem_ren;
      if (push_buf) begin
        buf_q[wr_q] <= mem_rdata;
        wr_q        <= ~wr_q;
      end
      if (pop_buf) rd_q <= ~rd_q;
      case ({push_buf, pop_buf})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
